// File: rtl/sd_dat_serializer.sv
// sd_dat_serializer: SD DAT0 block engine; sends start/data/CRC16/end on transmit and checks a received block against its CRC and end bit.
module sd_dat_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int CRC_WIDTH  = 16
) (
    input  logic                  sd_clock,
    input  logic                  reset,
    input  logic                  reset_wrapper,
    input  logic                  load_send,
    input  logic                  enable_pts_wrapper,
    input  logic                  enable_stp_wrapper,
    input  logic [DATA_WIDTH-1:0] data_from_fifo,
    input  logic                  dat_in,
    output logic                  dat_out,
    output logic                  dat_oe,
    output logic                  transmission_complete,
    output logic                  reception_complete,
    output logic [DATA_WIDTH-1:0] dataRead,
    output logic                  crc_error,
    output logic                  framing_error
);
    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_CRC, TX_END, TX_DONE,
        RX_WAIT, RX_DATA, RX_CRC, RX_END, RX_DONE
    } state_t;
    localparam logic [5:0] DATA_LAST = 6'(DATA_WIDTH - 1);
    localparam logic [5:0] CRC_LAST = 6'(CRC_WIDTH - 1);
    localparam logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(16'h1021);
    state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_read_q, data_read_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d, rcrc_q, rcrc_d, crc_upd;
    logic dat_out_q, dat_out_d, dat_oe_q, dat_oe_d, tc_q, tc_d, rc_q, rc_d;
    logic crc_err_q, crc_err_d, frm_err_q, frm_err_d, tx_abort, rx_abort;
    function automatic logic [CRC_WIDTH-1:0] crc_next(input logic [CRC_WIDTH-1:0] c, input logic b);
        return {c[CRC_WIDTH-2:0], 1'b0} ^ ((c[CRC_WIDTH-1] ^ b) ? POLY : '0);
    endfunction
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        shift_d = shift_q;
        crc_d = crc_q;
        rcrc_d = rcrc_q;
        dat_out_d = dat_out_q;
        dat_oe_d = dat_oe_q;
        tc_d = tc_q;
        rc_d = rc_q;
        data_read_d = data_read_q;
        crc_err_d = crc_err_q;
        frm_err_d = frm_err_q;
        // one shared CRC step: the outgoing MSB while transmitting, the pad bit while receiving
        crc_upd = crc_next(crc_q, state_q == TX_DATA ? shift_q[DATA_WIDTH-1] : dat_in);
        tx_abort = !enable_pts_wrapper && state_q inside {TX_START, TX_DATA, TX_CRC, TX_END};
        rx_abort = !enable_stp_wrapper && state_q inside {RX_WAIT, RX_DATA, RX_CRC, RX_END};
        if (reset_wrapper || tx_abort || rx_abort) begin
            state_d = IDLE;
            cnt_d = '0;
            crc_d = '0;
            dat_out_d = 1'b1;
            dat_oe_d = 1'b0;
            tc_d = 1'b0;
            rc_d = 1'b0;
            crc_err_d = 1'b0;
            frm_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_send && enable_pts_wrapper) begin
                        state_d = TX_START;
                        shift_d = data_from_fifo;
                        crc_d = '0;
                        cnt_d = '0;
                        dat_oe_d = 1'b1;
                        dat_out_d = 1'b0;
                    end else if (enable_stp_wrapper) begin
                        state_d = RX_WAIT;
                    end
                end
                TX_START: begin
                    state_d = TX_DATA;
                    cnt_d = '0;
                    dat_out_d = shift_q[DATA_WIDTH-1];
                end
                TX_DATA: begin
                    crc_d = crc_upd;
                    shift_d = shift_q << 1;
                    state_d = cnt_q == DATA_LAST ? TX_CRC : TX_DATA;
                    cnt_d = cnt_q == DATA_LAST ? 6'd0 : cnt_q + 6'd1;
                    dat_out_d = cnt_q == DATA_LAST ? crc_upd[CRC_WIDTH-1] : shift_q[DATA_WIDTH-2];
                end
                TX_CRC: begin
                    crc_d = crc_q << 1;
                    state_d = cnt_q == CRC_LAST ? TX_END : TX_CRC;
                    cnt_d = cnt_q == CRC_LAST ? 6'd0 : cnt_q + 6'd1;
                    dat_out_d = cnt_q == CRC_LAST ? 1'b1 : crc_q[CRC_WIDTH-2];
                end
                TX_END: begin
                    state_d = TX_DONE;
                    dat_oe_d = 1'b0;
                    dat_out_d = 1'b1;
                    tc_d = 1'b1;
                end
                RX_WAIT: begin
                    if (!dat_in) begin
                        state_d = RX_DATA;
                        cnt_d = '0;
                        crc_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], dat_in};
                    crc_d = crc_upd;
                    state_d = cnt_q == DATA_LAST ? RX_CRC : RX_DATA;
                    cnt_d = cnt_q == DATA_LAST ? 6'd0 : cnt_q + 6'd1;
                end
                RX_CRC: begin
                    rcrc_d = {rcrc_q[CRC_WIDTH-2:0], dat_in};
                    state_d = cnt_q == CRC_LAST ? RX_END : RX_CRC;
                    cnt_d = cnt_q == CRC_LAST ? 6'd0 : cnt_q + 6'd1;
                end
                RX_END: begin
                    state_d = RX_DONE;
                    rc_d = 1'b1;
                    data_read_d = shift_q;
                    crc_err_d = rcrc_q != crc_q;
                    frm_err_d = !dat_in;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            shift_q <= '0;
            crc_q <= '0;
            rcrc_q <= '0;
            dat_out_q <= 1'b1;
            dat_oe_q <= 1'b0;
            tc_q <= 1'b0;
            rc_q <= 1'b0;
            data_read_q <= '0;
            crc_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            shift_q <= shift_d;
            crc_q <= crc_d;
            rcrc_q <= rcrc_d;
            dat_out_q <= dat_out_d;
            dat_oe_q <= dat_oe_d;
            tc_q <= tc_d;
            rc_q <= rc_d;
            data_read_q <= data_read_d;
            crc_err_q <= crc_err_d;
            frm_err_q <= frm_err_d;
        end
    end
    assign dat_out = dat_out_q;
    assign dat_oe = dat_oe_q;
    assign transmission_complete = tc_q;
    assign reception_complete = rc_q;
    assign dataRead = data_read_q;
    assign crc_error = crc_err_q;
    assign framing_error = frm_err_q;
endmodule

// File: tb/tb_sd_dat_serializer.sv
// tb_sd_dat_serializer: scoreboard bench; stimulus queues expected DAT0 bits and completion events, a monitor pops and compares them.
module tb_sd_dat_serializer;
    logic sd_clock = 1'b0;
    logic reset = 1'b1, reset_wrapper = 1'b0, load_send = 1'b0;
    logic enable_pts_wrapper = 1'b0, enable_stp_wrapper = 1'b0, dat_in = 1'b1;
    logic [31:0] data_from_fifo = '0;
    logic dat_out, dat_oe, transmission_complete, reception_complete, crc_error, framing_error;
    logic [31:0] dataRead;
    typedef struct {
        int kind;
        logic [31:0] val;
        logic ce;
        logic fe;
    } exp_t;
    typedef logic [49:0] stream_t;
    exp_t sb[$];
    exp_t cur;
    int tests = 0, fails = 0;
    logic [31:0] last_read = '0;
    logic tc_prev = 1'b0, rc_prev = 1'b0, got;
    stream_t s;
    sd_dat_serializer dut (
        .sd_clock(sd_clock), .reset(reset), .reset_wrapper(reset_wrapper), .load_send(load_send),
        .enable_pts_wrapper(enable_pts_wrapper), .enable_stp_wrapper(enable_stp_wrapper),
        .data_from_fifo(data_from_fifo), .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe),
        .transmission_complete(transmission_complete), .reception_complete(reception_complete),
        .dataRead(dataRead), .crc_error(crc_error), .framing_error(framing_error)
    );
    always #5 sd_clock = ~sd_clock;
    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] model_crc(input logic [31:0] d);
        logic [47:0] r;
        r = {d, 16'h0};
        for (int i = 47; i >= 16; i--) if (r[i]) r = r ^ (48'h11021 << (i - 16));
        return r[15:0];
    endfunction
    function automatic stream_t make_stream(input logic [31:0] d);
        return {1'b0, d, model_crc(d), 1'b1};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic take(input int kind, output logic ok);
        ok = 1'b0;
        if (sb.size() == 0 || sb[0].kind != kind) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: unexpected event kind %0d (queue size %0d)", kind, sb.size());
        end else begin
            cur = sb.pop_front();
            ok = 1'b1;
        end
    endtask
    always @(negedge sd_clock) begin
        if (dat_oe === 1'b1) begin
            take(0, got);
            if (got) check("tx_bit", {31'b0, dat_out}, cur.val);
        end
        if (transmission_complete === 1'b1 && !tc_prev) take(1, got);
        if (reception_complete === 1'b1 && !rc_prev) begin
            take(2, got);
            if (got) begin
                check("rx_data", dataRead, cur.val);
                check("rx_crc_error", {31'b0, crc_error}, {31'b0, cur.ce});
                check("rx_framing_error", {31'b0, framing_error}, {31'b0, cur.fe});
            end
        end
        tc_prev = transmission_complete === 1'b1;
        rc_prev = reception_complete === 1'b1;
    end
    task automatic tick;
        @(posedge sd_clock);
        #1;
    endtask
    task automatic soft_clear;
        reset_wrapper = 1'b1;
        tick;
        reset_wrapper = 1'b0;
        check("clr_tc", {31'b0, transmission_complete}, 0);
        check("clr_rc", {31'b0, reception_complete}, 0);
        check("clr_flags", {30'b0, crc_error, framing_error}, 0);
        check("clr_pad", {30'b0, dat_oe, dat_out}, 1);
        check("clr_dataRead", dataRead, last_read);
        tick;
    endtask
    task automatic do_tx(input logic [31:0] d, input int abort_at, input logic both);
        stream_t st;
        int n, k;
        st = make_stream(d);
        n = abort_at < 0 ? 50 : abort_at;
        for (int i = 0; i < n; i++) sb.push_back('{0, {31'b0, st[49-i]}, 1'b0, 1'b0});
        if (abort_at < 0) sb.push_back('{1, 32'b0, 1'b0, 1'b0});
        data_from_fifo = d;
        load_send = 1'b1;
        enable_pts_wrapper = 1'b1;
        enable_stp_wrapper = both;
        tick;
        load_send = 1'b0;
        enable_stp_wrapper = 1'b0;
        data_from_fifo = $urandom;
        if (abort_at >= 0) begin
            repeat (abort_at - 1) tick;
            enable_pts_wrapper = 1'b0;
            tick;
            check("abort_oe", {31'b0, dat_oe}, 0);
            repeat (3) tick;
            check("abort_tc", {30'b0, transmission_complete, dat_out}, 1);
        end else begin
            k = 0;
            while (transmission_complete !== 1'b1 && k < 60) begin
                tick;
                k++;
            end
            check("tx_latency", k, 50);
            enable_pts_wrapper = 1'b0;
            load_send = 1'b1;
            tick;
            load_send = 1'b0;
            check("tx_done_hold", {30'b0, transmission_complete, dat_oe}, 2);
            soft_clear;
        end
    endtask
    task automatic do_rx(input stream_t st, input int idle);
        logic [31:0] pl;
        pl = st[48:17];
        sb.push_back('{2, pl, st[16:1] != model_crc(pl), !st[0]});
        last_read = pl;
        enable_stp_wrapper = 1'b1;
        dat_in = 1'b1;
        repeat (idle) tick;
        for (int i = 0; i < 50; i++) begin
            dat_in = st[49-i];
            tick;
        end
        dat_in = 1'b1;
        check("rx_latency", {31'b0, reception_complete}, 1);
        enable_stp_wrapper = 1'b0;
        tick;
        check("rx_done_hold", {31'b0, reception_complete}, 1);
        soft_clear;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) tick;
        reset = 1'b0;
        check("rst_pad", {30'b0, dat_oe, dat_out}, 1);
        check("rst_flags", {28'b0, transmission_complete, reception_complete, crc_error, framing_error}, 0);
        check("rst_dataRead", dataRead, 0);
        do_tx(32'h0, -1, 1'b0);
        do_tx(32'hA5A5_5A5A, -1, 1'b0);
        s = make_stream(32'hA5A5_5A5A);
        do_rx(s, 5);
        s[4] = ~s[4];
        do_rx(s, 5);
        s = make_stream(32'h0);
        s[0] = 1'b0;
        do_rx(s, 5);
        do_tx($urandom, 20, 1'b0);
        do_tx(32'hDEAD_BEEF, -1, 1'b1);
        enable_stp_wrapper = 1'b1;
        dat_in = 1'b1;
        repeat (2) tick;
        dat_in = 1'b0;
        tick;
        repeat (10) begin
            dat_in = 1'($urandom);
            tick;
        end
        enable_stp_wrapper = 1'b0;
        dat_in = 1'b1;
        tick;
        repeat (50) tick;
        check("rx_abort", {31'b0, reception_complete}, 0);
        check("rx_abort_dataRead", dataRead, last_read);
        for (int r = 0; r < 8; r++) begin
            logic [31:0] d;
            int mode;
            d = $urandom;
            do_tx(d, -1, 1'b0);
            s = make_stream(d);
            mode = $urandom_range(0, 3);
            if (mode == 1) s[$urandom_range(1, 48)] ^= 1'b1;
            if (mode == 2) s[0] = 1'b0;
            if (mode == 3) s[$urandom_range(1, 16)] ^= 1'b1;
            do_rx(s, $urandom_range(1, 6));
            if (r % 3 == 0) do_tx($urandom, $urandom_range(2, 49), 1'b0);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("final_reset_dataRead", dataRead, 0);
        check("final_reset_pad", {30'b0, dat_oe, dat_out}, 1);
        tick;
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
